tblock_dispatcher: RTL and testbench
====================================

// Module: tblock_dispatcher
// PURPOSE
// - Issues the thread blocks of one kernel launch to a compute unit's warp-allocation interface and retires them.
// - Sits upstream of the compute unit: drives allocate_* (pc, dp_addr, tblock_idx, tblock_id) and consumes tblock_done.
// - Manages unique in-flight tblock IDs and signals kernel completion once every block has reported done.
// PARAMETERS
// - PcWidth        32  program counter width
// - AddressWidth   32  data/parameter address width
// - TblockIdxBits   4  block index width; one launch holds at most 2**TblockIdxBits blocks
// - TblockIdBits    4  block ID width; at most 2**TblockIdBits blocks in flight
// - CycleCntWidth  32  width of kernel cycle counter (only with TBLOCK_DISPATCH_PERF_CNT_EN)
// PORTS
// - clk_i                  in   1                 clock
// - rst_ni                 in   1                 asynchronous reset, active-low
// - launch_valid_i         in   1                 kernel launch request
// - launch_ready_o         out  1                 launch accepted when valid&&ready
// - launch_pc_i            in   PcWidth           kernel start PC
// - launch_dp_addr_i       in   AddressWidth      data/parameter address
// - launch_num_tblocks_i   in   TblockIdxBits+1   blocks in launch (0..2**TblockIdxBits)
// - warp_free_i            in   1                 compute unit has a free warp
// - allocate_warp_o        out  1                 allocate block; transfer = allocate_warp_o && warp_free_i
// - allocate_pc_o          out  PcWidth           start PC of block
// - allocate_dp_addr_o     out  AddressWidth      data/parameter address of block
// - allocate_tblock_idx_o  out  TblockIdxBits     block index within launch
// - allocate_tblock_id_o   out  TblockIdBits      unique in-flight block ID
// - tblock_done_i          in   1                 block completion valid
// - tblock_done_id_i       in   TblockIdBits      ID of completed block
// - tblock_done_ready_o    out  1                 constant 1 after reset; completion accepted every cycle
// - kernel_done_o          out  1                 kernel complete, held until kernel_done_ready_i
// - kernel_done_ready_i    in   1                 kernel completion handshake
// - kernel_cycles_o        out  CycleCntWidth     launch-to-done cycles (port exists only with macro)
// BEHAVIOUR
// - Reset: state IDLE, ID bitmap all free, counters 0; launch_ready_o=1, allocate_warp_o=0, kernel_done_o=0,
//   allocate_* data=0, tblock_done_ready_o=1, kernel_cycles_o=0.
// - FSM IDLE: launch_ready_o=1; on handshake latch pc/dp_addr/num, clear dispatched/completed; num==0 -> DONE, else RUN.
// - FSM RUN: allocate_warp_o = (dispatched<num) && (any ID free); never depends combinationally on warp_free_i.
//   allocate_tblock_idx_o = dispatched; allocate_tblock_id_o = lowest free ID in registered bitmap.
//   On transfer: set ID bit, dispatched++. Data outputs stable while allocate_warp_o=1 and warp_free_i=0.
//   When completed==num (registered) -> DONE.
// - FSM DONE: kernel_done_o=1 until kernel_done_ready_i -> IDLE (launch_ready_o=0 during RUN and DONE; no overlap).
// - Completion: tblock_done_i clears bit tblock_done_id_i, completed++; one per cycle, zero-latency accept.
// - Same-cycle done(ID x) and allocate: allocator sees q bitmap; x reusable from next cycle. Both counters update same cycle.
// - All IDs busy: allocate_warp_o=0 until a completion frees one (next cycle earliest).
// - Counter width TblockIdxBits+1 so num==2**TblockIdxBits is representable; no wrap.
// - Last dispatch to DONE minimum latency: completion cycle +1.
// - Reset mid-operation: all state cleared, in-flight blocks forgotten; compute unit is reset together.
// - Assertions (non-SYNTHESIS): done ID must be set in bitmap; tblock_done_i never in IDLE; completed<=dispatched.
// CONFIGURATION
// - TBLOCK_DISPATCH_PERF_CNT_EN defined: kernel_cycles_o present; counter clears on launch handshake,
//   increments each RUN cycle, saturates at all-ones, holds through DONE/IDLE until next launch.
// - Undefined: no counter, no kernel_cycles_o port.
// STRUCTURE
// - Shared package bgpu_dispatch_pkg: dispatch_state_e {IDLE,RUN,DONE}, launch_req_t (pc, dp_addr, num_tblocks).
// - Sub-module tblock_id_allocator: ID bitmap, lowest-free search, alloc/free ports, any_free_o.
// - Top: FSM, dispatched/completed counters, latched launch request, optional perf counter.
// TESTING
// - Launch num=3, warp_free_i=1, done 2 cycles after each alloc -> idx 0,1,2 with IDs 0,1,2; one kernel_done_o.
// - Launch num=0 -> kernel_done_o the cycle after handshake; no allocate_warp_o.
// - TblockIdBits=2, num=8, no done -> exactly 4 allocs; done ID 1 -> next alloc uses ID 1 one cycle later.
// - warp_free_i=0 for 5 cycles -> allocate_warp_o and data held stable; transfer when warp_free_i rises.
// - Done ID 0 same cycle as alloc -> alloc gets lowest other free ID; completed and dispatched both increment.
// - Macro on: num=2, fixed latency -> kernel_cycles_o equals RUN cycles; rst_ni low mid-RUN -> reset values.

Source files
------------

// File: rtl/bgpu_dispatch_pkg.sv
// Shared types for the thread-block dispatcher: FSM states and the latched launch request.
package bgpu_dispatch_pkg;

    localparam int unsigned LaunchPcWidth   = 32;
    localparam int unsigned LaunchAddrWidth = 32;
    localparam int unsigned LaunchNumWidth  = 5;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } dispatch_state_e;

    typedef struct packed {
        logic [LaunchPcWidth-1:0]   pc;
        logic [LaunchAddrWidth-1:0] dp_addr;
        logic [LaunchNumWidth-1:0]  num_tblocks;
    } launch_req_t;

endpackage

// File: rtl/tblock_id_allocator.sv
// Tracks in-flight tblock IDs in a bitmap and offers the lowest free one.
// An offer that stalls is pinned so the offered ID stays stable until transferred.
module tblock_id_allocator #(
    parameter int unsigned IdBits = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              offer_i,
    input  logic              alloc_i,
    input  logic              free_i,
    input  logic [IdBits-1:0] free_id_i,
    output logic [IdBits-1:0] alloc_id_o,
    output logic              any_free_o,
    output logic              free_id_busy_o
);

    localparam int unsigned NumIds = 1 << IdBits;

    logic [NumIds-1:0] busy_q, busy_d;
    logic              hold_q, hold_d;
    logic [IdBits-1:0] held_id_q, held_id_d;
    logic [IdBits-1:0] lowest_free;

    always_comb begin
        lowest_free = '0;
        for (int i = NumIds - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                lowest_free = IdBits'(i);
            end
        end
    end

    assign any_free_o     = ~&busy_q;
    assign alloc_id_o     = hold_q ? held_id_q : lowest_free;
    assign free_id_busy_o = busy_q[free_id_i];

    always_comb begin
        busy_d    = busy_q;
        hold_d    = offer_i && !alloc_i;
        held_id_d = alloc_id_o;
        // Allocated ID is free in busy_q, so it can never collide with the freed one.
        if (alloc_i) begin
            busy_d[alloc_id_o] = 1'b1;
        end
        if (free_i) begin
            busy_d[free_id_i] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q    <= '0;
            hold_q    <= 1'b0;
            held_id_q <= '0;
        end else begin
            busy_q    <= busy_d;
            hold_q    <= hold_d;
            held_id_q <= held_id_d;
        end
    end

endmodule

// File: rtl/tblock_dispatcher.sv
// Issues the thread blocks of one kernel launch to a compute unit and retires them.
// Optional TBLOCK_DISPATCH_PERF_CNT_EN adds the kernel_cycles_o launch-to-done counter.
module tblock_dispatcher
    import bgpu_dispatch_pkg::*;
#(
    parameter int unsigned PcWidth       = 32,
    parameter int unsigned AddressWidth  = 32,
    parameter int unsigned TblockIdxBits = 4,
    parameter int unsigned TblockIdBits  = 4
`ifdef TBLOCK_DISPATCH_PERF_CNT_EN
    ,
    parameter int unsigned CycleCntWidth = 32
`endif
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     launch_valid_i,
    output logic                     launch_ready_o,
    input  logic [PcWidth-1:0]       launch_pc_i,
    input  logic [AddressWidth-1:0]  launch_dp_addr_i,
    input  logic [TblockIdxBits:0]   launch_num_tblocks_i,
    input  logic                     warp_free_i,
    output logic                     allocate_warp_o,
    output logic [PcWidth-1:0]       allocate_pc_o,
    output logic [AddressWidth-1:0]  allocate_dp_addr_o,
    output logic [TblockIdxBits-1:0] allocate_tblock_idx_o,
    output logic [TblockIdBits-1:0]  allocate_tblock_id_o,
    input  logic                     tblock_done_i,
    input  logic [TblockIdBits-1:0]  tblock_done_id_i,
    output logic                     tblock_done_ready_o,
    output logic                     kernel_done_o,
    input  logic                     kernel_done_ready_i
`ifdef TBLOCK_DISPATCH_PERF_CNT_EN
    ,
    output logic [CycleCntWidth-1:0] kernel_cycles_o
`endif
);

    localparam int unsigned CntW = TblockIdxBits + 1;

    dispatch_state_e state_q, state_d;
    launch_req_t     req_q, req_d;
    logic [CntW-1:0] dispatched_q, dispatched_d;
    logic [CntW-1:0] completed_q, completed_d;
    logic [CntW-1:0] num_tblocks;
    logic            any_free;
    logic            done_id_busy;
    logic            transfer;

    assign num_tblocks = CntW'(req_q.num_tblocks);
    assign transfer    = allocate_warp_o && warp_free_i;

    tblock_id_allocator #(
        .IdBits (TblockIdBits)
    ) u_id_alloc (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .offer_i        (allocate_warp_o),
        .alloc_i        (transfer),
        .free_i         (tblock_done_i),
        .free_id_i      (tblock_done_id_i),
        .alloc_id_o     (allocate_tblock_id_o),
        .any_free_o     (any_free),
        .free_id_busy_o (done_id_busy)
    );

    always_comb begin
        state_d         = state_q;
        req_d           = req_q;
        dispatched_d    = dispatched_q;
        completed_d     = completed_q;
        launch_ready_o  = 1'b0;
        allocate_warp_o = 1'b0;
        kernel_done_o   = 1'b0;
        unique case (state_q)
            IDLE: begin
                launch_ready_o = 1'b1;
                if (launch_valid_i) begin
                    req_d.pc          = LaunchPcWidth'(launch_pc_i);
                    req_d.dp_addr     = LaunchAddrWidth'(launch_dp_addr_i);
                    req_d.num_tblocks = LaunchNumWidth'(launch_num_tblocks_i);
                    dispatched_d      = '0;
                    completed_d       = '0;
                    state_d           = (launch_num_tblocks_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                allocate_warp_o = (dispatched_q < num_tblocks) && any_free;
                if (allocate_warp_o && warp_free_i) begin
                    dispatched_d = dispatched_q + 1'b1;
                end
                if (tblock_done_i) begin
                    completed_d = completed_q + 1'b1;
                end
                if (completed_q == num_tblocks) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                kernel_done_o = 1'b1;
                if (kernel_done_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign allocate_pc_o         = PcWidth'(req_q.pc);
    assign allocate_dp_addr_o    = AddressWidth'(req_q.dp_addr);
    assign allocate_tblock_idx_o = dispatched_q[TblockIdxBits-1:0];
    assign tblock_done_ready_o   = 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            req_q        <= '0;
            dispatched_q <= '0;
            completed_q  <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            dispatched_q <= dispatched_d;
            completed_q  <= completed_d;
        end
    end

`ifdef TBLOCK_DISPATCH_PERF_CNT_EN
    logic [CycleCntWidth-1:0] cycles_q, cycles_d;

    // Saturating count of RUN cycles, held after the kernel ends until the next launch.
    always_comb begin
        cycles_d = cycles_q;
        if (state_q == IDLE && launch_valid_i) begin
            cycles_d = '0;
        end else if (state_q == RUN && !(&cycles_q)) begin
            cycles_d = cycles_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    assign kernel_cycles_o = cycles_q;
`endif

`ifndef SYNTHESIS
    a_done_id_busy : assert property (@(posedge clk_i) disable iff (!rst_ni)
        tblock_done_i |-> done_id_busy);
    a_no_done_in_idle : assert property (@(posedge clk_i) disable iff (!rst_ni)
        tblock_done_i |-> (state_q != IDLE));
    a_completed_le_dispatched : assert property (@(posedge clk_i) disable iff (!rst_ni)
        completed_q <= dispatched_q);
`endif

endmodule

// File: tb/tb_tblock_dispatcher.sv
// Directed self-checking bench for tblock_dispatcher, built with a 4-ID pool.
// Covers TBLOCK_DISPATCH_PERF_CNT_EN checks when that macro is defined.
module tb_tblock_dispatcher;

    localparam int unsigned PcW  = 32;
    localparam int unsigned AdW  = 32;
    localparam int unsigned IdxB = 4;
    localparam int unsigned IdB  = 2;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            launch_valid_i = 1'b0;
    logic            launch_ready_o;
    logic [PcW-1:0]  launch_pc_i = '0;
    logic [AdW-1:0]  launch_dp_addr_i = '0;
    logic [IdxB:0]   launch_num_tblocks_i = '0;
    logic            warp_free_i = 1'b0;
    logic            allocate_warp_o;
    logic [PcW-1:0]  allocate_pc_o;
    logic [AdW-1:0]  allocate_dp_addr_o;
    logic [IdxB-1:0] allocate_tblock_idx_o;
    logic [IdB-1:0]  allocate_tblock_id_o;
    logic            tblock_done_i = 1'b0;
    logic [IdB-1:0]  tblock_done_id_i = '0;
    logic            tblock_done_ready_o;
    logic            kernel_done_o;
    logic            kernel_done_ready_i = 1'b0;
`ifdef TBLOCK_DISPATCH_PERF_CNT_EN
    logic [31:0]     kernel_cycles_o;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    tblock_dispatcher #(
        .PcWidth       (PcW),
        .AddressWidth  (AdW),
        .TblockIdxBits (IdxB),
        .TblockIdBits  (IdB)
    ) dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .launch_valid_i        (launch_valid_i),
        .launch_ready_o        (launch_ready_o),
        .launch_pc_i           (launch_pc_i),
        .launch_dp_addr_i      (launch_dp_addr_i),
        .launch_num_tblocks_i  (launch_num_tblocks_i),
        .warp_free_i           (warp_free_i),
        .allocate_warp_o       (allocate_warp_o),
        .allocate_pc_o         (allocate_pc_o),
        .allocate_dp_addr_o    (allocate_dp_addr_o),
        .allocate_tblock_idx_o (allocate_tblock_idx_o),
        .allocate_tblock_id_o  (allocate_tblock_id_o),
        .tblock_done_i         (tblock_done_i),
        .tblock_done_id_i      (tblock_done_id_i),
        .tblock_done_ready_o   (tblock_done_ready_o),
        .kernel_done_o         (kernel_done_o),
        .kernel_done_ready_i   (kernel_done_ready_i)
`ifdef TBLOCK_DISPATCH_PERF_CNT_EN
        ,
        .kernel_cycles_o       (kernel_cycles_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic launch(input logic [IdxB:0] num, input logic [PcW-1:0] pc,
                          input logic [AdW-1:0] dp);
        launch_valid_i       = 1'b1;
        launch_num_tblocks_i = num;
        launch_pc_i          = pc;
        launch_dp_addr_i     = dp;
        #1;
        check_eq("launch_ready", launch_ready_o, 1);
        cyc();
        launch_valid_i = 1'b0;
    endtask

    task automatic wait_kdone(input string tag);
        int n = 0;
        #1;
        while (!kernel_done_o && n < 10) begin
            cyc();
            #1;
            n++;
        end
        check_eq(tag, kernel_done_o, 1);
        kernel_done_ready_i = 1'b1;
        cyc();
        kernel_done_ready_i = 1'b0;
        #1;
        check_eq({tag, "_cleared"}, kernel_done_o, 0);
        check_eq({tag, "_ready_back"}, launch_ready_o, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;

        // Reset values
        #12;
        check_eq("rst_launch_ready", launch_ready_o, 1);
        check_eq("rst_alloc_warp", allocate_warp_o, 0);
        check_eq("rst_kernel_done", kernel_done_o, 0);
        check_eq("rst_done_ready", tblock_done_ready_o, 1);
        check_eq("rst_alloc_pc", allocate_pc_o, 0);
        check_eq("rst_alloc_id", allocate_tblock_id_o, 0);
`ifdef TBLOCK_DISPATCH_PERF_CNT_EN
        check_eq("rst_cycles", kernel_cycles_o, 0);
`endif
        @(negedge clk_i);
        rst_ni = 1'b1;
        cyc();

        // Three blocks, each done two cycles after its allocation
        warp_free_i = 1'b1;
        launch(5'd3, 32'h100, 32'h200);
        #1;
        check_eq("t1_warp0", allocate_warp_o, 1);
        check_eq("t1_idx0", allocate_tblock_idx_o, 0);
        check_eq("t1_id0", allocate_tblock_id_o, 0);
        check_eq("t1_pc", allocate_pc_o, 32'h100);
        check_eq("t1_dp", allocate_dp_addr_o, 32'h200);
        check_eq("t1_no_launch", launch_ready_o, 0);
        cyc();
        #1;
        check_eq("t1_idx1", allocate_tblock_idx_o, 1);
        check_eq("t1_id1", allocate_tblock_id_o, 1);
        cyc();
        tblock_done_i = 1'b1;
        tblock_done_id_i = 2'd0;
        #1;
        check_eq("t1_idx2", allocate_tblock_idx_o, 2);
        check_eq("t1_id2", allocate_tblock_id_o, 2);
        cyc();
        tblock_done_id_i = 2'd1;
        #1;
        check_eq("t1_all_dispatched", allocate_warp_o, 0);
        cyc();
        tblock_done_id_i = 2'd2;
        cyc();
        tblock_done_i = 1'b0;
        #1;
        check_eq("t1_not_done_yet", kernel_done_o, 0);
        cyc();
        #1;
        check_eq("t1_kernel_done", kernel_done_o, 1);
`ifdef TBLOCK_DISPATCH_PERF_CNT_EN
        check_eq("t1_cycles", kernel_cycles_o, 6);
`endif
        wait_kdone("t1_kdone");

        // Empty launch completes the cycle after the handshake
        launch(5'd0, 32'h0, 32'h0);
        #1;
        check_eq("t2_kernel_done", kernel_done_o, 1);
        check_eq("t2_no_alloc", allocate_warp_o, 0);
        check_eq("t2_no_launch", launch_ready_o, 0);
        wait_kdone("t2_kdone");

        // Eight blocks on a 4-ID pool with no completions
        launch(5'd8, 32'h180, 32'h280);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (allocate_warp_o && warp_free_i) begin
                check_eq("t3_alloc_id", allocate_tblock_id_o, cnt);
                cnt++;
            end
            cyc();
        end
        check_eq("t3_alloc_count", cnt, 4);
        tblock_done_i = 1'b1;
        tblock_done_id_i = 2'd1;
        #1;
        check_eq("t3_full_no_alloc", allocate_warp_o, 0);
        cyc();

        // Stall: offer for ID 1 must hold even though ID 0 frees mid-stall
        warp_free_i = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tblock_done_i = (s == 0);
            tblock_done_id_i = 2'd0;
            #1;
            check_eq("t4_stall_warp", allocate_warp_o, 1);
            check_eq("t4_stall_id", allocate_tblock_id_o, 1);
            check_eq("t4_stall_idx", allocate_tblock_idx_o, 4);
            check_eq("t4_stall_pc", allocate_pc_o, 32'h180);
            cyc();
        end
        tblock_done_i = 1'b0;
        warp_free_i = 1'b1;
        #1;
        check_eq("t4_release_id", allocate_tblock_id_o, 1);
        check_eq("t4_release_idx", allocate_tblock_idx_o, 4);
        cyc();
        #1;
        check_eq("t4_next_id", allocate_tblock_id_o, 0);
        check_eq("t4_next_idx", allocate_tblock_idx_o, 5);
        cyc();
        tblock_done_i = 1'b1;
        tblock_done_id_i = 2'd2;
        #1;
        check_eq("t3_pool_full", allocate_warp_o, 0);
        cyc();

        // Same-cycle completion of ID 0 and allocation
        tblock_done_id_i = 2'd0;
        #1;
        check_eq("t5_warp", allocate_warp_o, 1);
        check_eq("t5_id", allocate_tblock_id_o, 2);
        check_eq("t5_idx", allocate_tblock_idx_o, 6);
        check_eq("t5_completed_before", dut.completed_q, 3);
        check_eq("t5_dispatched_before", dut.dispatched_q, 6);
        cyc();
        tblock_done_i = 1'b0;
        #1;
        check_eq("t5_completed_after", dut.completed_q, 4);
        check_eq("t5_dispatched_after", dut.dispatched_q, 7);
        check_eq("t5_reuse_id", allocate_tblock_id_o, 0);
        check_eq("t5_idx7", allocate_tblock_idx_o, 7);
        cyc();
        for (int k = 0; k < 4; k++) begin
            tblock_done_i = 1'b1;
            tblock_done_id_i = IdB'(k);
            #1;
            if (k == 0) check_eq("t5_all_dispatched", allocate_warp_o, 0);
            cyc();
        end
        tblock_done_i = 1'b0;
        wait_kdone("t5_kdone");

        // Reset in the middle of a run
        launch(5'd2, 32'h300, 32'h310);
        #1;
        check_eq("t6_warp", allocate_warp_o, 1);
        cyc();
        rst_ni = 1'b0;
        #1;
        check_eq("t6_rst_launch_ready", launch_ready_o, 1);
        check_eq("t6_rst_warp", allocate_warp_o, 0);
        check_eq("t6_rst_idx", allocate_tblock_idx_o, 0);
        check_eq("t6_rst_id", allocate_tblock_id_o, 0);
        check_eq("t6_rst_pc", allocate_pc_o, 0);
        check_eq("t6_rst_kdone", kernel_done_o, 0);
`ifdef TBLOCK_DISPATCH_PERF_CNT_EN
        check_eq("t6_rst_cycles", kernel_cycles_o, 0);
`endif
        @(negedge clk_i);
        rst_ni = 1'b1;
        cyc();
        launch(5'd1, 32'h400, 32'h410);
        #1;
        check_eq("t6_fresh_id", allocate_tblock_id_o, 0);
        check_eq("t6_fresh_idx", allocate_tblock_idx_o, 0);
        check_eq("t6_fresh_pc", allocate_pc_o, 32'h400);
        cyc();
        cyc();
        tblock_done_i = 1'b1;
        tblock_done_id_i = 2'd0;
        cyc();
        tblock_done_i = 1'b0;
        wait_kdone("t6_kdone");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
